cursor_move_ctrl: RTL and testbench

CURSOR_MOVE_CTRL -- requirements
Module: cursor_move_ctrl

---
 rtl/cursor_move_ctrl_if.sv | 30 +++
 rtl/cursor_move_ctrl.sv | 178 +++++++++++++++++
 tb/tb_cursor_move_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cursor_move_ctrl_if.sv
// cursor_move_ctrl_if
// Groups the mouse-movement handshake and the video-slot write bus of the
// cursor controller into one bundle.
//   mv_valid/mv_ready : movement packet handshake (dx, dy, btn carried with it)
//   cs/write/addr/wr_data : single-cycle writes into the sprite cursor core
// Modports:
//   master : packet source / video-slot observer (drives mv_*, dx, dy, btn)
//   slave  : the controller (accepts packets, drives the video slot)

interface cursor_move_ctrl_if;
    logic        mv_valid;
    logic        mv_ready;
    logic [8:0]  dx;
    logic [8:0]  dy;
    logic        btn;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;

    modport master (
        output mv_valid, dx, dy, btn,
        input  mv_ready, cs, write, addr, wr_data
    );

    modport slave (
        input  mv_valid, dx, dy, btn,
        output mv_ready, cs, write, addr, wr_data
    );
endinterface

// File: rtl/cursor_move_ctrl.sv
// cursor_move_ctrl
// Tracks the cursor position from mouse movement packets and pushes the
// position and button state into the sprite cursor core once per frame, at
// the start of vertical blanking.
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   y       : current line from the frame counter
//   bus     : packet handshake in, video-slot writes out (slave modport)
//
// FSM states
//   state   | meaning
//   IDLE    | accept packets, wait for vblank start
//   WR_BYP  | write 0 to 0x2000 (first frame after reset only)
//   WR_X    | write pos_x to 0x2001
//   WR_Y    | write pos_y to 0x2002
//   WR_CTRL | write button ctrl word to 0x2003

module cursor_move_ctrl #(
    parameter int         H_MAX      = 640,
    parameter int         V_MAX      = 480,
    parameter int         SPRITE_W   = 32,
    parameter int         SPRITE_H   = 32,
    parameter int         X_INIT     = 304,
    parameter int         Y_INIT     = 224,
    parameter logic [4:0] CTRL_IDLE  = 5'b00100,
    parameter logic [4:0] CTRL_CLICK = 5'b01000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [10:0]          y,
    cursor_move_ctrl_if.slave    bus
);

    localparam int X_MAX = H_MAX - SPRITE_W;
    localparam int Y_MAX = V_MAX - SPRITE_H;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BYP  = 3'd1,
        WR_X    = 3'd2,
        WR_Y    = 3'd3,
        WR_CTRL = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [10:0] pos_x;
    logic [10:0] pos_y;
    logic [10:0] pos_x_nx;
    logic [10:0] pos_y_nx;
    logic [11:0] sum_x;
    logic [11:0] sum_y;
    logic        btn_reg;
    logic        pd;
    logic        cd;
    logic        vb_d;
    logic        init_pend;
    logic        vb;
    logic        vb_start;
    logic        accept;
    logic        btn_chg;

    assign vb       = (y >= 11'(V_MAX));
    assign vb_start = vb & ~vb_d;
    assign accept   = bus.mv_valid & bus.mv_ready;
    assign btn_chg  = accept & (bus.btn != btn_reg);

    // Ready is gated by reset directly so it drops while reset is held.
    assign bus.mv_ready = (state == IDLE) & reset_n;

    // 12-bit two's complement sums; bit 11 set means the result went negative.
    assign sum_x = {1'b0, pos_x} + {{3{bus.dx[8]}}, bus.dx};
    assign sum_y = {1'b0, pos_y} - {{3{bus.dy[8]}}, bus.dy};

    always_comb begin
        pos_x_nx = sum_x[10:0];
        if (sum_x[11])
            pos_x_nx = '0;
        else if (sum_x > 12'(X_MAX))
            pos_x_nx = 11'(X_MAX);

        pos_y_nx = sum_y[10:0];
        if (sum_y[11])
            pos_y_nx = '0;
        else if (sum_y > 12'(Y_MAX))
            pos_y_nx = 11'(Y_MAX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pos_x     <= 11'(X_INIT);
            pos_y     <= 11'(Y_INIT);
            btn_reg   <= 1'b0;
            pd        <= 1'b1;
            cd        <= 1'b1;
            vb_d      <= 1'b1;
            init_pend <= 1'b1;
        end else begin
            state <= state_nx;
            vb_d  <= vb;
            if (accept) begin
                pos_x <= pos_x_nx;
                pos_y <= pos_y_nx;
                pd    <= 1'b1;
            end
            if (btn_chg) begin
                btn_reg <= bus.btn;
                cd      <= 1'b1;
            end
            // Packets are stalled outside IDLE, so these clears never race an accept.
            if (state == WR_Y)
                pd <= 1'b0;
            if (state == WR_CTRL)
                cd <= 1'b0;
            if (state == IDLE && vb_start)
                init_pend <= 1'b0;
        end
    end

    // A packet accepted on the vblank start cycle counts as already pending,
    // so its new position is what WR_X sends.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (vb_start) begin
                    if (init_pend)
                        state_nx = WR_BYP;
                    else if (pd || accept)
                        state_nx = WR_X;
                    else if (cd || btn_chg)
                        state_nx = WR_CTRL;
                end
            end
            WR_BYP:  state_nx = WR_X;
            WR_X:    state_nx = WR_Y;
            WR_Y:    state_nx = cd ? WR_CTRL : IDLE;
            WR_CTRL: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.cs      = 1'b0;
        bus.write   = 1'b0;
        bus.addr    = '0;
        bus.wr_data = '0;
        case (state)
            WR_BYP: begin
                bus.cs      = 1'b1;
                bus.write   = 1'b1;
                bus.addr    = 14'h2000;
            end
            WR_X: begin
                bus.cs      = 1'b1;
                bus.write   = 1'b1;
                bus.addr    = 14'h2001;
                bus.wr_data = {21'b0, pos_x};
            end
            WR_Y: begin
                bus.cs      = 1'b1;
                bus.write   = 1'b1;
                bus.addr    = 14'h2002;
                bus.wr_data = {21'b0, pos_y};
            end
            WR_CTRL: begin
                bus.cs      = 1'b1;
                bus.write   = 1'b1;
                bus.addr    = 14'h2003;
                bus.wr_data = {27'b0, btn_reg ? CTRL_CLICK : CTRL_IDLE};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// tb_cursor_move_ctrl
// Drives a free-running 525-line frame counter, directed and random mouse
// packets, and reset pulses into cursor_move_ctrl. A reference model keeps
// the cursor position, dirty flags and a queue of the video-slot writes each
// vblank should produce; every DUT cycle is compared against it.

module tb_cursor_move_ctrl;

    localparam int LINES  = 525;
    localparam int NFRAME = 30;
    localparam int XM     = 640 - 32;
    localparam int YM     = 480 - 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] y = '0;

    cursor_move_ctrl_if bus();

    cursor_move_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .y       (y),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // reference model
    int          m_x, m_y;
    bit          m_btn, m_pd, m_cd, m_init, m_prev_vb;
    int          busy;
    logic [45:0] exp_q[$];

    task automatic model_reset();
        m_x = 304; m_y = 224; m_btn = 0;
        m_pd = 1; m_cd = 1; m_init = 1; m_prev_vb = 1;
        busy = 0;
        exp_q.delete();
    endtask

    function automatic logic [45:0] wr(input int a, input int d);
        return {14'(a), 32'(d)};
    endfunction

    task automatic vblank_writes();
        int n;
        n = 0;
        if (m_init) begin
            exp_q.push_back(wr(32'h2000, 0));
            n++;
            m_init = 0;
        end
        if (n > 0 || m_pd) begin
            exp_q.push_back(wr(32'h2001, m_x));
            exp_q.push_back(wr(32'h2002, m_y));
            n += 2;
        end
        if (n > 0 || m_cd) begin
            exp_q.push_back(wr(32'h2003, m_btn ? 8 : 4));
            n++;
        end
        // a write sequence that carries X/Y but no ctrl change ends after Y
        if (n == 3 && !m_cd) begin
            void'(exp_q.pop_back());
            n--;
        end
        m_pd = 0;
        m_cd = 0;
        busy = n;
    endtask

    // stimulus state
    bit          pk_v = 0;
    logic [8:0]  pk_dx = '0, pk_dy = '0;
    bit          pk_btn = 0;
    bit          rnd_btn = 0;
    bit          acc_prev = 0;
    int          f, yy;

    task automatic load_pkt(input logic [8:0] ddx, input logic [8:0] ddy, input bit b);
        pk_v = 1; pk_dx = ddx; pk_dy = ddy; pk_btn = b;
    endtask

    task automatic schedule();
        if (f == 1 && yy == 10)  load_pkt(9'd255, 9'd214, 1'b0);
        if (f == 1 && yy == 20)  load_pkt(9'd41,  9'd0,   1'b0);
        if (f == 1 && yy == 30)  load_pkt(9'd100, 9'd50,  1'b0);
        if (f == 2 && yy == 10)  load_pkt(9'd0,   9'd0,   1'b1);
        if (f == 3 && yy == 480) load_pkt(9'h1F8, 9'd0,   1'b1);
        if (f == 3 && yy == 482) load_pkt(9'd3,   9'h1FD, 1'b1);
        if (f == 4 && yy == 5)   load_pkt(9'd7,   9'd7,   1'b1);
        if (f >= 6 && $urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 3) == 0)
                rnd_btn = ~rnd_btn;
            load_pkt(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), rnd_btn);
        end
    endtask

    task automatic model_cycle();
        bit exp_busy, acc, vb;
        if (!reset_n) begin
            model_reset();
            chk("rst_cs", bus.cs, 0);
            chk("rst_ready", bus.mv_ready, 0);
            chk("rst_bus", {bus.write, bus.addr, bus.wr_data}, 0);
            acc_prev = 0;
            return;
        end
        exp_busy = (busy > 0);
        chk("cs", bus.cs, exp_busy);
        chk("mv_ready", bus.mv_ready, !exp_busy);
        if (bus.cs) begin
            chk("write", bus.write, 1);
            if (exp_q.size() == 0)
                chk("extra_write", {bus.addr, bus.wr_data}, 0);
            else
                chk("wr", {bus.addr, bus.wr_data}, exp_q.pop_front());
        end else begin
            chk("idle_bus", {bus.write, bus.addr, bus.wr_data}, 0);
        end
        if (busy > 0)
            busy--;
        acc = bus.mv_valid && !exp_busy;
        if (acc) begin
            m_x = m_x + $signed(bus.dx);
            m_y = m_y - $signed(bus.dy);
            if (m_x < 0)  m_x = 0;
            if (m_x > XM) m_x = XM;
            if (m_y < 0)  m_y = 0;
            if (m_y > YM) m_y = YM;
            m_pd = 1;
            if (bus.btn != m_btn) begin
                m_btn = bus.btn;
                m_cd = 1;
            end
        end
        vb = (yy >= 480);
        if (vb && !m_prev_vb)
            vblank_writes();
        m_prev_vb = vb;
        if (yy == 500)
            chk("pending_writes", exp_q.size(), 0);
        acc_prev = acc;
    endtask

    initial begin
        model_reset();
        bus.mv_valid = 0; bus.dx = '0; bus.dy = '0; bus.btn = 0;
        for (int c = 0; c < NFRAME * LINES; c++) begin
            f  = c / LINES;
            yy = c % LINES;
            y  = 11'(yy);
            reset_n = !(c < 3 || (f == 4 && yy == 481));
            if (acc_prev)
                pk_v = 0;
            if (!pk_v)
                schedule();
            bus.mv_valid = pk_v;
            bus.dx       = pk_dx;
            bus.dy       = pk_dy;
            bus.btn      = pk_btn;
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
